// File: rtl/gate_bist.sv
// gate_bist: exhaustive 2-input gate tester, drives 00,01,10,11 on A/B and checks Y against func
// Ports: clk/rst (sync, active-high); start launches a run and latches func (00 AND, 01 OR,
// 10 XOR, 11 NAND); A/B stimulus out, Y response in; busy during a run; done/pass/fail_count/
// first_fail report the last run and hold until the next accepted start or reset.
module gate_bist #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] func,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [1:0] first_fail
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, state_n;
    logic [1:0] func_q, vec;
    logic [3:0] cnt;
    logic       accept, last, exp_y, miss;
    always_comb begin
        accept  = start && state != RUN;
        last    = state == RUN && cnt == 4'(SETTLE - 1);
        exp_y   = func_q == 2'b00 ? vec[1] & vec[0] :
                  func_q == 2'b01 ? vec[1] | vec[0] :
                  func_q == 2'b10 ? vec[1] ^ vec[0] : ~(vec[1] & vec[0]);
        miss    = last && Y != exp_y;
        state_n = accept ? RUN : (last && vec == 2'd3) ? DONE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            func_q     <= 2'b00;
            vec        <= 2'd0;
            cnt        <= 4'd0;
            fail_count <= 3'd0;
            first_fail <= 2'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                func_q     <= func;
                vec        <= 2'd0;
                cnt        <= 4'd0;
                fail_count <= 3'd0;
                first_fail <= 2'd0;
            end else if (state == RUN) begin
                cnt <= last ? 4'd0 : cnt + 4'd1;
                // vec wraps to 0 after vector 3, leaving it cleared in DONE
                if (last) vec <= vec + 2'd1;
                if (miss) begin
                    fail_count <= fail_count + 3'd1;
                    if (fail_count == 3'd0) first_fail <= vec;
                end
            end
        end
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    assign pass = done && fail_count == 3'd0;
    assign A    = busy & vec[1];
    assign B    = busy & vec[0];
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed bench for gate_bist with a modelled gate under test and a result scoreboard
module tb_gate_bist;
    logic       clk = 0, rst = 1, start0 = 0, start1 = 0, sel = 0;
    logic [1:0] func = 2'b00;
    int         mode = 0;
    logic       A0, B0, Y0, busy0, done0, pass0, A1, B1, Y1, busy1, done1, pass1;
    logic [2:0] fc0, fc1;
    logic [1:0] ff0, ff1;
    logic       a_o, b_o, busy_o, done_o, pass_o;
    logic [2:0] fc_o;
    logic [1:0] ff_o;
    int         vectors = 0, errors = 0;

    typedef struct {
        logic [2:0] fc;
        logic [1:0] ff;
        logic       ps;
    } res_t;
    res_t sb[$];

    // gate under test: 0 ideal AND, 1 output stuck at 0, 2 ideal XOR
    function automatic logic gate_y(input int m, input logic a, input logic b);
        return m == 0 ? a & b : m == 1 ? 1'b0 : a ^ b;
    endfunction

    function automatic logic fexp(input logic [1:0] f, input logic a, input logic b);
        case (f)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    always #5 clk = ~clk;

    assign Y0 = gate_y(mode, A0, B0);
    assign Y1 = gate_y(mode, A1, B1);

    gate_bist #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start0), .func(func), .A(A0), .B(B0), .Y(Y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0), .first_fail(ff0)
    );

    gate_bist #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .func(func), .A(A1), .B(B1), .Y(Y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .first_fail(ff1)
    );

    assign a_o    = sel ? A1 : A0;
    assign b_o    = sel ? B1 : B0;
    assign busy_o = sel ? busy1 : busy0;
    assign done_o = sel ? done1 : done0;
    assign pass_o = sel ? pass1 : pass0;
    assign fc_o   = sel ? fc1 : fc0;
    assign ff_o   = sel ? ff1 : ff0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 8'(busy_o), 8'd0);
        chk({tag, "_done"}, 8'(done_o), 8'd0);
        chk({tag, "_pass"}, 8'(pass_o), 8'd0);
        chk({tag, "_fc"}, 8'(fc_o), 8'd0);
        chk({tag, "_ff"}, 8'(ff_o), 8'd0);
        chk({tag, "_ab"}, 8'({a_o, b_o}), 8'd0);
    endtask

    // one complete run; poke re-pulses start and flips func partway through
    task automatic run(input logic s, input logic [1:0] f, input int m, input int settle, input bit poke);
        res_t       r;
        logic [2:0] fc = 0;
        logic [1:0] ff = 0;
        int         c = 0;
        sel  = s;
        func = f;
        mode = m;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v = 2'(i);
            if (gate_y(m, v[1], v[0]) !== fexp(f, v[1], v[0])) begin
                if (fc == 0) ff = v;
                fc++;
            end
        end
        r.fc = fc;
        r.ff = ff;
        r.ps = fc == 0;
        sb.push_back(r);
        if (s) start1 = 1; else start0 = 1;
        @(negedge clk);
        start0 = 0;
        start1 = 0;
        chk("done_drop", 8'(done_o), 8'd0);
        while (busy_o === 1'b1 && c < 200) begin
            chk("ab_step", 8'({a_o, b_o}), 8'(c / settle));
            if (poke && c == 2) begin
                if (s) start1 = 1; else start0 = 1;
                func = ~f;
            end
            if (poke && c == 3) begin
                start0 = 0;
                start1 = 0;
            end
            @(negedge clk);
            c++;
        end
        start0 = 0;
        start1 = 0;
        chk("busy_cycles", 8'(c), 8'(4 * settle));
        r = sb.pop_front();
        chk("done", 8'(done_o), 8'd1);
        chk("pass", 8'(pass_o), 8'(r.ps));
        chk("fail_count", 8'(fc_o), 8'(r.fc));
        chk("first_fail", 8'(ff_o), 8'(r.ff));
        chk("ab_idle", 8'({a_o, b_o}), 8'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 0;
        @(negedge clk);
        chk_reset("idle");
        run(0, 2'b00, 0, 2, 0);
        run(0, 2'b01, 1, 2, 0);
        repeat (3) @(negedge clk);
        chk("hold_fc", 8'(fc_o), 8'd3);
        chk("hold_ff", 8'(ff_o), 8'd1);
        chk("hold_done", 8'(done_o), 8'd1);
        run(0, 2'b11, 0, 2, 0);
        run(0, 2'b00, 0, 2, 0);
        run(0, 2'b10, 0, 2, 1);
        // abort a failing run during vector 2
        func   = 2'b01;
        mode   = 1;
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        repeat (4) @(negedge clk);
        chk("abort_fc_before", 8'(fc_o), 8'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_reset("abort");
        run(0, 2'b01, 1, 2, 0);
        run(1, 2'b10, 2, 1, 0);
        rst    = 1;
        start1 = 1;
        @(negedge clk);
        rst    = 0;
        start1 = 0;
        chk_reset("rst_start");
        @(negedge clk);
        chk("rst_start_idle", 8'(busy_o), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
